// File: rtl/mmips_sim_devq_if.sv
// rtl/mmips_sim_devq_if.sv - mMIPS device port and bench-side channel bundle
interface mmips_sim_devq_if #(
  parameter int DW  = 32,
  parameter int NCH = 2
);
  logic [DW-1:0]     dev_dout;
  logic [DW-1:0]     dev_din;
  logic              dev_r;
  logic              dev_w;
  logic              dev_wdata;
  logic              dev_waddr;
  logic              dev_send_eop;
  logic              dev_rdyr;
  logic              dev_rdyw;
  logic              dev_rcv_eop;
  logic [NCH-1:0]    tb_in_valid;
  logic [NCH*DW-1:0] tb_in_data;
  logic [NCH-1:0]    tb_in_eop;
  logic [NCH-1:0]    tb_in_ready;
  logic [NCH-1:0]    tb_out_valid;
  logic [NCH*DW-1:0] tb_out_data;
  logic [NCH-1:0]    tb_out_eop;
  logic [NCH-1:0]    tb_out_ready;

  modport master (
    output dev_dout, dev_r, dev_w, dev_wdata, dev_waddr, dev_send_eop,
    output tb_in_valid, tb_in_data, tb_in_eop, tb_out_ready,
    input  dev_din, dev_rdyr, dev_rdyw, dev_rcv_eop,
    input  tb_in_ready, tb_out_valid, tb_out_data, tb_out_eop
  );

  modport slave (
    input  dev_dout, dev_r, dev_w, dev_wdata, dev_waddr, dev_send_eop,
    input  tb_in_valid, tb_in_data, tb_in_eop, tb_out_ready,
    output dev_din, dev_rdyr, dev_rdyw, dev_rcv_eop,
    output tb_in_ready, tb_out_valid, tb_out_data, tb_out_eop
  );
endinterface

// File: rtl/mmips_sim_devq.sv
// rtl/mmips_sim_devq.sv - multi-channel simulation device with TX/RX FIFOs and eop tags
module mmips_sim_devq #(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int NCH   = 2,
  localparam int SW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  mmips_sim_devq_if.slave dev,
  output logic [SW-1:0] sel,
  output logic          err
);
  localparam int AW = $clog2(DEPTH);

  typedef logic [DW:0] entry_t;
  typedef logic [AW:0] ptr_t;

  entry_t          tx_mem_q [NCH][DEPTH];
  entry_t          tx_mem_d [NCH][DEPTH];
  entry_t          rx_mem_q [NCH][DEPTH];
  entry_t          rx_mem_d [NCH][DEPTH];
  ptr_t            tx_wp_q [NCH];
  ptr_t            tx_wp_d [NCH];
  ptr_t            tx_rp_q [NCH];
  ptr_t            tx_rp_d [NCH];
  ptr_t            rx_wp_q [NCH];
  ptr_t            rx_wp_d [NCH];
  ptr_t            rx_rp_q [NCH];
  ptr_t            rx_rp_d [NCH];
  logic [SW-1:0]   sel_q, sel_d;
  logic            err_q, err_d;
  logic [DW-1:0]   din_q, din_d;
  logic            rcv_eop_q, rcv_eop_d;
  logic [NCH-1:0]  tx_full, tx_empty, rx_full, rx_empty;
  logic            sel_wr, dat_wr;

  // Full/empty come from registered pointers only; the extra MSB tells full from empty.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      tx_empty[c] = (tx_wp_q[c] == tx_rp_q[c]);
      tx_full[c]  = (tx_wp_q[c][AW] != tx_rp_q[c][AW]) &&
                    (tx_wp_q[c][AW-1:0] == tx_rp_q[c][AW-1:0]);
      rx_empty[c] = (rx_wp_q[c] == rx_rp_q[c]);
      rx_full[c]  = (rx_wp_q[c][AW] != rx_rp_q[c][AW]) &&
                    (rx_wp_q[c][AW-1:0] == rx_rp_q[c][AW-1:0]);
    end
  end

  assign dev.dev_rdyr     = en & ~rx_empty[sel_q];
  assign dev.dev_rdyw     = en & ~tx_full[sel_q];
  assign dev.tb_in_ready  = en ? ~rx_full : '0;
  assign dev.tb_out_valid = en ? ~tx_empty : '0;
  assign dev.dev_din      = din_q;
  assign dev.dev_rcv_eop  = rcv_eop_q;
  assign sel              = sel_q;
  assign err              = err_q;

  always_comb begin
    dev.tb_out_data = '0;
    dev.tb_out_eop  = '0;
    for (int c = 0; c < NCH; c++) begin
      dev.tb_out_data[c*DW +: DW] = tx_mem_q[c][tx_rp_q[c][AW-1:0]][DW-1:0];
      dev.tb_out_eop[c]           = tx_mem_q[c][tx_rp_q[c][AW-1:0]][DW];
    end
  end

  // A select write takes priority over a data write when both qualifiers are set.
  assign sel_wr = dev.dev_w & dev.dev_waddr;
  assign dat_wr = dev.dev_w & ~dev.dev_waddr & dev.dev_wdata;

  always_comb begin
    tx_mem_d  = tx_mem_q;
    rx_mem_d  = rx_mem_q;
    tx_wp_d   = tx_wp_q;
    tx_rp_d   = tx_rp_q;
    rx_wp_d   = rx_wp_q;
    rx_rp_d   = rx_rp_q;
    sel_d     = sel_q;
    err_d     = err_q;
    din_d     = din_q;
    rcv_eop_d = rcv_eop_q;
    if (en) begin
      if (sel_wr) begin
        if (dev.dev_dout < DW'(NCH)) sel_d = dev.dev_dout[SW-1:0];
        else                         err_d = 1'b1;
      end
      if (dat_wr) begin
        if (dev.dev_rdyw) begin
          tx_mem_d[sel_q][tx_wp_q[sel_q][AW-1:0]] = {dev.dev_send_eop, dev.dev_dout};
          tx_wp_d[sel_q] = tx_wp_q[sel_q] + ptr_t'(1);
        end else begin
          err_d = 1'b1;
        end
      end
      if (dev.dev_r) begin
        if (dev.dev_rdyr) begin
          din_d          = rx_mem_q[sel_q][rx_rp_q[sel_q][AW-1:0]][DW-1:0];
          rcv_eop_d      = rx_mem_q[sel_q][rx_rp_q[sel_q][AW-1:0]][DW];
          rx_rp_d[sel_q] = rx_rp_q[sel_q] + ptr_t'(1);
        end else begin
          err_d = 1'b1;
        end
      end
      for (int c = 0; c < NCH; c++) begin
        if (dev.tb_in_valid[c] && dev.tb_in_ready[c]) begin
          rx_mem_d[c][rx_wp_q[c][AW-1:0]] = {dev.tb_in_eop[c], dev.tb_in_data[c*DW +: DW]};
          rx_wp_d[c] = rx_wp_q[c] + ptr_t'(1);
        end
        if (dev.tb_out_valid[c] && dev.tb_out_ready[c]) begin
          tx_rp_d[c] = tx_rp_q[c] + ptr_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        tx_wp_q[c] <= '0;
        tx_rp_q[c] <= '0;
        rx_wp_q[c] <= '0;
        rx_rp_q[c] <= '0;
      end
      sel_q     <= '0;
      err_q     <= 1'b0;
      din_q     <= '0;
      rcv_eop_q <= 1'b0;
    end else begin
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      sel_q     <= sel_d;
      err_q     <= err_d;
      din_q     <= din_d;
      rcv_eop_q <= rcv_eop_d;
    end
  end
endmodule

// File: tb/tb_mmips_sim_devq.sv
// tb/tb_mmips_sim_devq.sv - queue-model bench for mmips_sim_devq
module tb_mmips_sim_devq;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int NCH   = 2;
  localparam int SW    = 1;

  logic          clk;
  logic          rst;
  logic          en;
  logic [SW-1:0] sel;
  logic          err;

  mmips_sim_devq_if #(.DW(DW), .NCH(NCH)) bus ();

  mmips_sim_devq #(.DW(DW), .DEPTH(DEPTH), .NCH(NCH)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .dev (bus),
    .sel (sel),
    .err (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  logic [DW:0]   txq [NCH][$];
  logic [DW:0]   rxq [NCH][$];
  int            sel_m   = 0;
  logic          err_m   = 1'b0;
  logic [DW-1:0] din_m   = '0;
  logic          eop_m   = 1'b0;
  int            rx_pops = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.dev_dout     = '0;
    bus.dev_r        = 1'b0;
    bus.dev_w        = 1'b0;
    bus.dev_wdata    = 1'b0;
    bus.dev_waddr    = 1'b0;
    bus.dev_send_eop = 1'b0;
    bus.tb_in_valid  = '0;
    bus.tb_in_data   = '0;
    bus.tb_in_eop    = '0;
    bus.tb_out_ready = '0;
  endtask

  // Model advances on the current inputs, then one clock passes and every output is compared.
  task automatic cycle();
    int s;
    int nsel;
    bit txp;
    bit rxp;
    bit [NCH-1:0] bpop;
    bit [NCH-1:0] bpush;
    logic [DW:0] w;
    s = sel_m; nsel = sel_m; txp = 0; rxp = 0; bpop = '0; bpush = '0;
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        txq[c].delete();
        rxq[c].delete();
      end
      sel_m = 0; err_m = 1'b0; din_m = '0; eop_m = 1'b0;
    end else if (en) begin
      if (bus.dev_w && bus.dev_waddr) begin
        if (bus.dev_dout < NCH) nsel = int'(bus.dev_dout);
        else err_m = 1'b1;
      end else if (bus.dev_w && bus.dev_wdata) begin
        if (txq[s].size() < DEPTH) txp = 1;
        else err_m = 1'b1;
      end
      if (bus.dev_r) begin
        if (rxq[s].size() > 0) rxp = 1;
        else err_m = 1'b1;
      end
      for (int c = 0; c < NCH; c++) begin
        bpop[c]  = bus.tb_out_ready[c] && (txq[c].size() > 0);
        bpush[c] = bus.tb_in_valid[c] && (rxq[c].size() < DEPTH);
      end
      if (rxp) begin
        w = rxq[s].pop_front();
        din_m = w[DW-1:0];
        eop_m = w[DW];
        rx_pops++;
      end
      for (int c = 0; c < NCH; c++) if (bpop[c]) w = txq[c].pop_front();
      if (txp) txq[s].push_back({bus.dev_send_eop, bus.dev_dout});
      for (int c = 0; c < NCH; c++)
        if (bpush[c]) rxq[c].push_back({bus.tb_in_eop[c], bus.tb_in_data[c*DW +: DW]});
      sel_m = nsel;
    end
    @(posedge clk);
    #1;
    chk("sel", 64'(sel), 64'(sel_m));
    chk("err", 64'(err), 64'(err_m));
    chk("dev_din", 64'(bus.dev_din), 64'(din_m));
    chk("dev_rcv_eop", 64'(bus.dev_rcv_eop), 64'(eop_m));
    chk("dev_rdyr", 64'(bus.dev_rdyr), 64'(en && rxq[sel_m].size() > 0));
    chk("dev_rdyw", 64'(bus.dev_rdyw), 64'(en && txq[sel_m].size() < DEPTH));
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("tb_in_ready%0d", c), 64'(bus.tb_in_ready[c]), 64'(en && rxq[c].size() < DEPTH));
      chk($sformatf("tb_out_valid%0d", c), 64'(bus.tb_out_valid[c]), 64'(en && txq[c].size() > 0));
      if (txq[c].size() > 0) begin
        chk($sformatf("tb_out_data%0d", c), 64'(bus.tb_out_data[c*DW +: DW]), 64'(txq[c][0][DW-1:0]));
        chk($sformatf("tb_out_eop%0d", c), 64'(bus.tb_out_eop[c]), 64'(txq[c][0][DW]));
      end
    end
  endtask

  task automatic cpu_wr(input logic [DW-1:0] d, input logic eop);
    bus.dev_w = 1'b1; bus.dev_wdata = 1'b1; bus.dev_waddr = 1'b0;
    bus.dev_dout = d; bus.dev_send_eop = eop;
    cycle();
    bus.dev_w = 1'b0; bus.dev_wdata = 1'b0; bus.dev_send_eop = 1'b0;
  endtask

  task automatic sel_wr(input logic [DW-1:0] v);
    bus.dev_w = 1'b1; bus.dev_waddr = 1'b1; bus.dev_wdata = 1'b0; bus.dev_dout = v;
    cycle();
    bus.dev_w = 1'b0; bus.dev_waddr = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_a [3];
    exp_a[0] = 32'hA0; exp_a[1] = 32'hA1; exp_a[2] = 32'hA2;
    idle();
    en  = 1'b1;
    rst = 1'b0;

    // Reset with bench pushes asserted: nothing may land
    bus.tb_in_valid = '1;
    bus.tb_in_data  = {32'h1111_1111, 32'h2222_2222};
    cycle();
    cycle();
    chk("rst_rdyr", 64'(bus.dev_rdyr), 64'd0);
    chk("rst_rdyw", 64'(bus.dev_rdyw), 64'd1);
    chk("rst_sel", 64'(sel), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    idle();
    rst = 1'b1;
    cycle();

    // CPU packet on ch0, drained by the bench in order
    cpu_wr(32'hA0, 1'b0);
    cpu_wr(32'hA1, 1'b0);
    cpu_wr(32'hA2, 1'b1);
    bus.tb_out_ready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      chk("pkt_data", 64'(bus.tb_out_data[31:0]), 64'(exp_a[i]));
      chk("pkt_eop", 64'(bus.tb_out_eop[0]), 64'(i == 2));
      cycle();
    end
    bus.tb_out_ready = '0;
    chk("pkt_drained", 64'(bus.tb_out_valid[0]), 64'd0);

    // Select ch1, bench pushes one word, CPU reads it
    sel_wr(1);
    bus.tb_in_valid = 2'b10;
    bus.tb_in_data  = {32'h55, 32'h0};
    bus.tb_in_eop   = 2'b10;
    cycle();
    idle();
    bus.dev_r = 1'b1;
    cycle();
    bus.dev_r = 1'b0;
    chk("rd_din", 64'(bus.dev_din), 64'h55);
    chk("rd_eop", 64'(bus.dev_rcv_eop), 64'd1);
    chk("rd_rdyr", 64'(bus.dev_rdyr), 64'd0);

    // Fill TX0, overflow, then simultaneous pop and refused write
    sel_wr(0);
    for (int i = 0; i < DEPTH; i++) cpu_wr($urandom, 1'($urandom_range(0, 1)));
    chk("full_rdyw", 64'(bus.dev_rdyw), 64'd0);
    cpu_wr(32'hDEAD, 1'b0);
    chk("ovf_err", 64'(err), 64'd1);
    bus.tb_out_ready = 2'b01;
    cpu_wr(32'hBEEF, 1'b1);
    chk("pop_ok_rdyw", 64'(bus.dev_rdyw), 64'd1);
    for (int i = 0; i < DEPTH; i++) cycle();
    bus.tb_out_ready = '0;
    chk("tx0_empty", 64'(bus.tb_out_valid[0]), 64'd0);

    // Illegal select, then frozen cycles with every strobe active
    sel_wr(1);
    sel_wr(NCH);
    chk("bad_sel", 64'(sel), 64'd1);
    bus.dev_w = 1'b1; bus.dev_wdata = 1'b1; bus.dev_dout = 32'h77;
    bus.dev_r = 1'b1;
    bus.tb_in_valid = '1; bus.tb_out_ready = '1;
    en = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    en = 1'b1;
    idle();
    cycle();

    // Random traffic on all channels
    for (int i = 0; i < 300; i++) begin
      en               = ($urandom_range(0, 9) != 0);
      bus.dev_w        = 1'($urandom_range(0, 1));
      bus.dev_waddr    = ($urandom_range(0, 5) == 0);
      bus.dev_wdata    = 1'($urandom_range(0, 1));
      bus.dev_dout     = bus.dev_waddr ? 32'($urandom_range(0, 2)) : $urandom;
      bus.dev_send_eop = 1'($urandom_range(0, 1));
      bus.dev_r        = 1'($urandom_range(0, 1));
      bus.tb_in_valid  = 2'($urandom);
      bus.tb_in_data   = {$urandom, $urandom};
      bus.tb_in_eop    = 2'($urandom);
      bus.tb_out_ready = 2'($urandom);
      cycle();
    end
    en = 1'b1;
    idle();

    // Stream 3*DEPTH words through RX0 across pointer wrap
    sel_wr(0);
    while (rxq[0].size() > 0) begin
      bus.dev_r = 1'b1;
      cycle();
    end
    idle();
    rx_pops = 0;
    for (int i = 0; i < 400 && rx_pops < 3 * DEPTH; i++) begin
      bus.tb_in_valid  = {1'b0, 1'($urandom_range(0, 1))};
      bus.tb_in_data   = {32'h0, $urandom};
      bus.tb_in_eop    = {1'b0, 1'($urandom_range(0, 1))};
      bus.dev_r        = 1'($urandom_range(0, 1));
      cycle();
    end
    chk("wrap_done", 64'(rx_pops >= 3 * DEPTH), 64'd1);

    // Mid-stream reset with both directions occupied
    idle();
    bus.tb_in_valid = 2'b11;
    bus.tb_in_data  = {$urandom, $urandom};
    bus.dev_w = 1'b1; bus.dev_wdata = 1'b1; bus.dev_dout = 32'hC0DE;
    cycle();
    rst = 1'b0;
    cycle();
    chk("mid_rst_rdyr", 64'(bus.dev_rdyr), 64'd0);
    chk("mid_rst_txv", 64'(bus.tb_out_valid), 64'd0);
    chk("mid_rst_rdyw", 64'(bus.dev_rdyw), 64'd1);
    chk("mid_rst_err", 64'(err), 64'd0);
    idle();
    rst = 1'b1;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
